// File: rtl/mult_io_pkg.sv
// Shared definitions for the radix-4 multiplier board I/O front end.
package mult_io_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } deb_state_t;

    localparam int BTN_START  = 0;
    localparam int BTN_GETA   = 1;
    localparam int BTN_GETB   = 2;
    localparam int BTN_PUTOUT = 3;

    // 1 ms at a 50 MHz system clock
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/button_conditioner_if.sv
// Board-side button/switch bundle: raw pads in, conditioned levels and pulses out.
interface button_conditioner_if #(
    parameter int NUM_BTN = 4,
    parameter int SW_W    = 8
) ();

    logic [NUM_BTN-1:0] btn_raw;
    logic [SW_W-1:0]    sw_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [SW_W-1:0]    sw_sync;

    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  sw_sync
    );

    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output sw_sync
    );

endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// One button: optional inversion, multi-flop synchroniser, counted debounce FSM
// with registered level and press/release pulses.
module debounce_fsm
    import mult_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                   w_in;
    logic                   w_synced;
    logic [SYNC_STAGES-1:0] r_sync;
    deb_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    // Normalise to 1 = pressed so the synchroniser resets to the released value
    assign w_in     = BTN_ACTIVE_LOW ? ~i_raw : i_raw;
    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                REL: begin
                    r_cnt <= '0;
                    if (w_synced) r_state <= CHK_P;
                end
                CHK_P: begin
                    if (!w_synced) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRS: begin
                    r_cnt <= '0;
                    if (!w_synced) r_state <= CHK_R;
                end
                CHK_R: begin
                    if (w_synced) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= REL;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= REL;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Multiplier input front end: per-button debounce instances plus a plain
// synchroniser for the operand data switches.
module button_conditioner
    import mult_io_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SW_W            = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave bus
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [SW_W-1:0]    r_sw [SYNC_STAGES];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_fsm #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (bus.btn_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    // Switches are only synchronised; the controller's load strobes qualify capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sw[i] <= '0;
        end else begin
            r_sw[0] <= bus.sw_raw;
            for (int i = 1; i < SYNC_STAGES; i++) r_sw[i] <= r_sw[i-1];
        end
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.sw_sync     = r_sw[SYNC_STAGES-1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low pads.
module tb_button_conditioner;

    localparam int NB   = 4;
    localparam int SW   = 8;
    localparam int LAT  = 7;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    button_conditioner_if #(.NUM_BTN(NB), .SW_W(SW)) bus ();

    button_conditioner #(
        .NUM_BTN         (NB),
        .SW_W            (SW),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.btn_raw = '1;
        bus.sw_raw  = 8'h5A;
        #2;
        n_tests++;
        if (bus.btn_level !== 4'b0000 || bus.btn_press !== 4'b0000 ||
            bus.btn_release !== 4'b0000 || bus.sw_sync !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: level=%b press=%b rel=%b sw=%h required all zero",
                     bus.btn_level, bus.btn_press, bus.btn_release, bus.sw_sync);
        end
        idle(2);
        #1;
        n_tests++;
        if (bus.sw_sync !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sw_held: sw=%h required 00", bus.sw_sync);
        end
        @(negedge clk);
        rst        = 1'b1;
        bus.sw_raw = 8'h00;
        idle(4);
    endtask

    task automatic test_clean_press();
        logic [NB-1:0] exp_lvl;
        logic [NB-1:0] exp_prs;
        logic [NB-1:0] exp_rel;
        @(negedge clk);
        bus.btn_raw[1] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp_lvl = (e >= LAT) ? 4'b0010 : 4'b0000;
            exp_prs = (e == LAT) ? 4'b0010 : 4'b0000;
            n_tests++;
            if (bus.btn_level !== exp_lvl || bus.btn_press !== exp_prs || bus.btn_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: level=%b press=%b rel=%b required %b %b 0000",
                         e, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_prs);
            end
        end
        @(negedge clk);
        bus.btn_raw[1] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp_lvl = (e >= LAT) ? 4'b0000 : 4'b0010;
            exp_rel = (e == LAT) ? 4'b0010 : 4'b0000;
            n_tests++;
            if (bus.btn_level !== exp_lvl || bus.btn_release !== exp_rel || bus.btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL clean_release edge %0d: level=%b rel=%b press=%b required %b %b 0000",
                         e, bus.btn_level, bus.btn_release, bus.btn_press, exp_lvl, exp_rel);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [15];
        logic [NB-1:0] exp_lvl;
        logic [NB-1:0] exp_prs;
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            bus.btn_raw[0] = pat[c];
            @(posedge clk); #1;
            n_tests++;
            if (bus.btn_level !== 4'b0000 || bus.btn_press !== 4'b0000 || bus.btn_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: level=%b press=%b rel=%b required 0000 0000 0000",
                         c, bus.btn_level, bus.btn_press, bus.btn_release);
            end
        end
        @(negedge clk);
        bus.btn_raw[0] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp_lvl = (e >= LAT) ? 4'b0001 : 4'b0000;
            exp_prs = (e == LAT) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (bus.btn_level !== exp_lvl || bus.btn_press !== exp_prs) begin
                n_fail++;
                $display("FAIL bounce_accept edge %0d: level=%b press=%b required %b %b",
                         e, bus.btn_level, bus.btn_press, exp_lvl, exp_prs);
            end
        end
        @(negedge clk);
        bus.btn_raw[0] = 1'b1;
        idle(10);
    endtask

    task automatic test_release();
        logic [NB-1:0] exp_lvl;
        logic [NB-1:0] exp_rel;
        @(negedge clk);
        bus.btn_raw[3] = 1'b0;
        idle(10);
        #1;
        n_tests++;
        if (bus.btn_level !== 4'b1000) begin
            n_fail++;
            $display("FAIL release_setup: level=%b required 1000", bus.btn_level);
        end
        @(negedge clk);
        bus.btn_raw[3] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp_lvl = (e >= LAT) ? 4'b0000 : 4'b1000;
            exp_rel = (e == LAT) ? 4'b1000 : 4'b0000;
            n_tests++;
            if (bus.btn_level !== exp_lvl || bus.btn_release !== exp_rel || bus.btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL release edge %0d: level=%b rel=%b press=%b required %b %b 0000",
                         e, bus.btn_level, bus.btn_release, bus.btn_press, exp_lvl, exp_rel);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] exp_lvl;
        logic [NB-1:0] exp_prs;
        @(negedge clk);
        bus.btn_raw[3] = 1'b0;
        bus.sw_raw     = 8'h3C;
        idle(10);
        #1;
        n_tests++;
        if (bus.btn_level !== 4'b1000 || bus.sw_sync !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_mid_setup: level=%b sw=%h required 1000 3c", bus.btn_level, bus.sw_sync);
        end
        @(negedge clk);
        bus.btn_raw[2] = 1'b0;
        idle(4);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.btn_level !== 4'b0000 || bus.btn_press !== 4'b0000 ||
            bus.btn_release !== 4'b0000 || bus.sw_sync !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: level=%b press=%b rel=%b sw=%h required all zero",
                     bus.btn_level, bus.btn_press, bus.btn_release, bus.sw_sync);
        end
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp_lvl = (e >= LAT) ? 4'b1100 : 4'b0000;
            exp_prs = (e == LAT) ? 4'b1100 : 4'b0000;
            n_tests++;
            if (bus.btn_level !== exp_lvl || bus.btn_press !== exp_prs || bus.btn_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_repress edge %0d: level=%b press=%b rel=%b required %b %b 0000",
                         e, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_prs);
            end
        end
        @(negedge clk);
        bus.btn_raw[3] = 1'b1;
        bus.btn_raw[2] = 1'b1;
        idle(10);
    endtask

    task automatic test_simultaneous();
        logic [NB-1:0] exp_lvl;
        logic [NB-1:0] exp_prs;
        logic [SW-1:0] exp_sw;
        @(negedge clk);
        bus.btn_raw[1] = 1'b0;
        bus.btn_raw[2] = 1'b0;
        bus.sw_raw     = 8'hA5;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            exp_lvl = (e >= LAT) ? 4'b0110 : 4'b0000;
            exp_prs = (e == LAT) ? 4'b0110 : 4'b0000;
            exp_sw  = (e >= 2) ? 8'hA5 : 8'h3C;
            n_tests++;
            if (bus.btn_level !== exp_lvl || bus.btn_press !== exp_prs || bus.sw_sync !== exp_sw) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: level=%b press=%b sw=%h required %b %b %h",
                         e, bus.btn_level, bus.btn_press, bus.sw_sync, exp_lvl, exp_prs, exp_sw);
            end
        end
        @(negedge clk);
        bus.btn_raw[1] = 1'b1;
        bus.btn_raw[2] = 1'b1;
        idle(10);
        #1;
        n_tests++;
        if (bus.btn_level !== 4'b0000) begin
            n_fail++;
            $display("FAIL simultaneous_release: level=%b required 0000", bus.btn_level);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_reset_mid();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input front end for the FPGA radix-4 multiplier. It takes the raw board push-buttons (start, getA, getB, putOut) and the 8-bit data switches. It synchronises, debounces and edge-detects the buttons, and delivers clean levels to the multiplier controller. It also delivers one-cycle press/release pulses for any other consumer, plus synchronised switch data for the operand byte registers.

## Interface
Parameters:
- `NUM_BTN`, 4: number of buttons. Bit mapping: 0 = start, 1 = getA, 2 = getB, 3 = putOut.
- `SW_W`, 8: data-switch width (one operand byte).
- `SYNC_STAGES`, 2: flip-flop synchroniser depth (≥2).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed to accept a change (1 ms at 50 MHz). Must be ≥2.
- `BTN_ACTIVE_LOW`, 1: when 1, raw buttons read 0 when pressed and are inverted before the synchroniser.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  NUM_BTN  raw pad inputs, asynchronous.
- `sw_raw`  in  SW_W  raw switch inputs, asynchronous.
- `btn_level`  out  NUM_BTN  debounced pressed-state (1 = pressed); drives controller `start/getA/getB/putOut`.
- `btn_press`  out  NUM_BTN  one-cycle pulse on accepted press.
- `btn_release`  out  NUM_BTN  one-cycle pulse on accepted release.
- `sw_sync`  out  SW_W  switches after SYNC_STAGES flops, not debounced.

## Operation
- Per button: optional inversion, then an SYNC_STAGES synchroniser, then a 4-state debounce FSM with a private counter of width clog2(DEBOUNCE_CYCLES).
- FSM states: `REL` (stable released), `CHK_P` (candidate press), `PRS` (stable pressed), `CHK_R` (candidate release).
- In `REL`, if synced = 1, go to `CHK_P` with counter = 0. Otherwise stay, with counter held at 0.
- In `CHK_P`:
  - synced = 0: return to `REL` and clear the counter (glitch rejected, no pulse).
  - synced = 1 and counter = DEBOUNCE_CYCLES−1: go to `PRS`; `btn_level` ← 1; `btn_press` = 1 for that cycle.
  - otherwise: counter + 1.
- `PRS` and `CHK_R` mirror the above with polarity swapped. Commit sets `btn_level` ← 0 and pulses `btn_release`.
- `btn_level` is 1 in exactly `PRS` and `CHK_R`. `btn_press` and `btn_release` are registered and mutually exclusive per button.
- The buttons are fully independent. Simultaneous activity on several buttons produces independent, possibly coincident pulses.
- The counter never wraps; it is cleared on every state entry.
- Switches are synchronised only. Operand capture is qualified by the controller's loadLsb/loadMsb strobes.

## Timing
- Reset (rst = 0, asynchronous) forces the following, independent of clock:
  - all FSMs to `REL`, counters to 0, synchroniser flops to the released value;
  - `btn_level` = 0, `btn_press` = 0, `btn_release` = 0, `sw_sync` = 0.
- Reset may arrive mid-debounce or while a button is held. After release, a held button is re-debounced from `REL` and produces a fresh press pulse after full latency.
- Reset deassertion is synchronised externally. The block adds no reset synchroniser.
- Press latency: let edge 1 be the first rising edge that samples the new raw value. `btn_level` and `btn_press` update at edge SYNC_STAGES + 1 + DEBOUNCE_CYCLES. Release latency is identical.
- A bounce pulse of synced width < DEBOUNCE_CYCLES never changes `btn_level`.
- `sw_sync` latency is SYNC_STAGES edges.

## Structure
- Shared package `mult_io_pkg`:
  - debounce state enum {REL, CHK_P, PRS, CHK_R};
  - button index constants BTN_START = 0, BTN_GETA = 1, BTN_GETB = 2, BTN_PUTOUT = 3;
  - default DEBOUNCE_CYCLES.
- One sub-module, `debounce_fsm`: the single-bit synchroniser, counter and FSM. The top instantiates it NUM_BTN times via generate and adds the switch synchroniser.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2, BTN_ACTIVE_LOW = 1.
- Clean press: drive `btn_raw[1]` from 1 to 0 and hold → `btn_level[1]` rises and `btn_press[1]` pulses for exactly 1 cycle at edge 7. No other bit changes.
- Bounce rejection: `btn_raw[0]` low for 3 cycles, high for 2, low for 3, then high → `btn_level` stays 0 and no pulses occur. A subsequent 10-cycle low is accepted at edge 7 of that low.
- Release: hold `btn_raw[3]` pressed until the level is 1, then set it to 1 → `btn_release[3]` pulses once and `btn_level[3]` drops 7 edges after the raw change.
- Reset mid-operation: assert `rst` = 0 during `CHK_P` while the button is held low → outputs go to 0 immediately. After deassertion, the press is re-accepted 7 edges later with a single `btn_press`.
- Simultaneous: press buttons 1 and 2 on the same cycle → both `btn_press` bits pulse on the same cycle. `sw_raw` = 8'hA5 appears on `sw_sync` after 2 edges.
